// File: rtl/match_event_reporter.sv
// Holdoff-filtered matched-filter event reporter: timestamps accepted matches and queues them in a show-ahead FIFO.
// Define MATCH_REPORTER_IRQ_EN to add the IRQ_LEVEL parameter and the irq output.
module match_event_reporter #(
   parameter int unsigned FIFO_AW = 3
`ifdef MATCH_REPORTER_IRQ_EN
   , parameter int unsigned IRQ_LEVEL = 1
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rxstrobe,
   input  logic               valid,
   input  logic               match,
   input  logic [15:0]        holdoff,
   input  logic               ev_rd,
   output logic [31:0]        ev_data,
   output logic               ev_empty,
   output logic [FIFO_AW:0]   ev_count,
   output logic [15:0]        match_total,
   output logic [15:0]        drop_total
`ifdef MATCH_REPORTER_IRQ_EN
   , output logic             irq
`endif
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = FIFO_AW + 1;

   logic [30:0]        sample_idx_q, sample_idx_d;
   logic [15:0]        ho_cnt_q, ho_cnt_d;
   logic [31:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               empty_q;
   logic               lost_q, lost_d;
   logic [15:0]        match_total_q, match_total_d;
   logic [15:0]        drop_total_q, drop_total_d;
   logic               qual, accept, full, do_rd, do_wr, drop;

   // Acceptance, FIFO control and counter next-state
   always_comb begin
      qual   = valid & match;
      accept = qual & (ho_cnt_q == 16'd0);
      full   = (count_q == CW'(DEPTH));
      do_rd  = ev_rd & (count_q != CW'(0));
      do_wr  = accept & (~full | do_rd);
      drop   = accept & full & ~do_rd;

      sample_idx_d = rxstrobe ? sample_idx_q + 31'd1 : sample_idx_q;

      ho_cnt_d = ho_cnt_q;
      if (accept) begin
         ho_cnt_d = holdoff;
      end else if (rxstrobe && (ho_cnt_q != 16'd0)) begin
         ho_cnt_d = ho_cnt_q - 16'd1;
      end

      wr_ptr_d = do_wr ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

      count_d = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + CW'(1);
      end else if (do_rd && !do_wr) begin
         count_d = count_q - CW'(1);
      end

      lost_d = lost_q;
      if (drop) begin
         lost_d = 1'b1;
      end else if (do_wr) begin
         lost_d = 1'b0;
      end

      match_total_d = (qual && (match_total_q != 16'hFFFF)) ? match_total_q + 16'd1 : match_total_q;
      drop_total_d  = (drop && (drop_total_q != 16'hFFFF)) ? drop_total_q + 16'd1 : drop_total_q;
   end

   // State registers; storage is cleared on reset so the idle head reads zero
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_idx_q  <= '0;
         ho_cnt_q      <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         empty_q       <= 1'b1;
         lost_q        <= 1'b0;
         match_total_q <= '0;
         drop_total_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         sample_idx_q  <= sample_idx_d;
         ho_cnt_q      <= ho_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         empty_q       <= (count_d == CW'(0));
         lost_q        <= lost_d;
         match_total_q <= match_total_d;
         drop_total_q  <= drop_total_d;
         if (do_wr) begin
            mem_q[wr_ptr_q] <= {lost_q, sample_idx_q};
         end
      end
   end

`ifdef MATCH_REPORTER_IRQ_EN
   logic irq_q;

   // Occupancy threshold, lagging ev_count by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (count_q >= CW'(IRQ_LEVEL));
      end
   end

   assign irq = irq_q;
`endif

   assign ev_data     = mem_q[rd_ptr_q];
   assign ev_empty    = empty_q;
   assign ev_count    = count_q;
   assign match_total = match_total_q;
   assign drop_total  = drop_total_q;

endmodule

// File: tb/tb_match_event_reporter.sv
// Self-checking bench for match_event_reporter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_match_event_reporter;

   localparam int unsigned FIFO_AW = 3;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned IRQ_LVL = 2;

   logic        clk;
   logic        reset;
   logic        rxstrobe;
   logic        valid;
   logic        match;
   logic [15:0] holdoff;
   logic        ev_rd;
   logic [31:0] ev_data;
   logic        ev_empty;
   logic [3:0]  ev_count;
   logic [15:0] match_total;
   logic [15:0] drop_total;
`ifdef MATCH_REPORTER_IRQ_EN
   logic        irq;
`endif

   match_event_reporter #(
      .FIFO_AW     (FIFO_AW)
`ifdef MATCH_REPORTER_IRQ_EN
      , .IRQ_LEVEL (IRQ_LVL)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rxstrobe    (rxstrobe),
      .valid       (valid),
      .match       (match),
      .holdoff     (holdoff),
      .ev_rd       (ev_rd),
      .ev_data     (ev_data),
      .ev_empty    (ev_empty),
      .ev_count    (ev_count),
      .match_total (match_total),
      .drop_total  (drop_total)
`ifdef MATCH_REPORTER_IRQ_EN
      , .irq       (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] mq[$];
   int unsigned m_idx;
   int unsigned m_ho;
   bit          m_lost;
   int unsigned m_mt;
   int unsigned m_dt;
   bit          exp_irq;

   typedef struct {
      bit          rx;
      bit          v;
      bit          m;
      bit          rd;
      int unsigned cnt;
      logic [31:0] data;
      int unsigned mt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void model_tick(input bit rst, input bit rx, input bit v, input bit m, input bit rd);
      bit qual, acc, rdok, full;
      exp_irq = rst ? 1'b0 : (mq.size() >= IRQ_LVL);
      if (rst) begin
         mq.delete();
         m_idx = 0; m_ho = 0; m_lost = 0; m_mt = 0; m_dt = 0;
         return;
      end
      qual = v && m;
      acc  = qual && (m_ho == 0);
      rdok = rd && (mq.size() > 0);
      full = (mq.size() == DEPTH);
      if (qual && m_mt < 65535) m_mt++;
      if (rdok) void'(mq.pop_front());
      if (acc) begin
         if (full && !rdok) begin
            if (m_dt < 65535) m_dt++;
            m_lost = 1'b1;
         end else begin
            mq.push_back({m_lost, m_idx[30:0]});
            m_lost = 1'b0;
         end
      end
      if (acc) m_ho = holdoff;
      else if (rx && m_ho > 0) m_ho--;
      if (rx) m_idx = (m_idx + 1) & 32'h7FFF_FFFF;
   endfunction

   // Apply one cycle of inputs, advance the model and compare all outputs after the edge
   task automatic step(input bit rst, input bit rx, input bit v, input bit m, input bit rd);
      reset = rst; rxstrobe = rx; valid = v; match = m; ev_rd = rd;
      @(posedge clk);
      model_tick(rst, rx, v, m, rd);
      #1;
      chk("empty", 32'(ev_empty), 32'(mq.size() == 0));
      chk("count", 32'(ev_count), 32'(mq.size()));
      if (mq.size() != 0) chk("data", ev_data, mq[0]);
      else if (rst) chk("reset_data", ev_data, 32'h0);
      chk("match_total", 32'(match_total), m_mt);
      chk("drop_total", 32'(drop_total), m_dt);
`ifdef MATCH_REPORTER_IRQ_EN
      chk("irq", 32'(irq), 32'(exp_irq));
`endif
      reset = 1'b0; rxstrobe = 1'b0; valid = 1'b0; match = 1'b0; ev_rd = 1'b0;
   endtask

   vec_t tbl[11];
   logic [31:0] wrap_exp[3];
   int lost_seen;

   initial begin
      reset = 1'b1; rxstrobe = 1'b0; valid = 1'b0; match = 1'b0; ev_rd = 1'b0; holdoff = 16'd0;

      // Reset state
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("rst_empty", 32'(ev_empty), 32'd1);
      chk("rst_count", 32'(ev_count), 32'd0);
      chk("rst_data", ev_data, 32'd0);
      chk("rst_mt", 32'(match_total), 32'd0);
      chk("rst_dt", 32'(drop_total), 32'd0);

      // Holdoff=4 table: matches at sample indices 10, 12, 14, 15 (only 10 and 15 accepted)
      tbl[0]  = '{1, 1, 1, 0, 1, 32'd10, 1};
      tbl[1]  = '{1, 0, 0, 0, 1, 32'd10, 1};
      tbl[2]  = '{1, 1, 1, 0, 1, 32'd10, 2};
      tbl[3]  = '{1, 0, 0, 0, 1, 32'd10, 2};
      tbl[4]  = '{1, 1, 1, 0, 1, 32'd10, 3};
      tbl[5]  = '{1, 1, 1, 0, 2, 32'd10, 4};
      tbl[6]  = '{0, 0, 0, 1, 1, 32'd15, 4};
      tbl[7]  = '{0, 0, 0, 1, 0, 32'd0,  4};
      tbl[8]  = '{0, 0, 0, 1, 0, 32'd0,  4};
      tbl[9]  = '{0, 0, 1, 0, 0, 32'd0,  4};
      tbl[10] = '{0, 1, 0, 0, 0, 32'd0,  4};
      holdoff = 16'd4;
      for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 11; i++) begin
         step(0, tbl[i].rx, tbl[i].v, tbl[i].m, tbl[i].rd);
         chk($sformatf("tbl%0d_count", i), 32'(ev_count), tbl[i].cnt);
         chk($sformatf("tbl%0d_empty", i), 32'(ev_empty), 32'(tbl[i].cnt == 0));
         if (tbl[i].cnt != 0) chk($sformatf("tbl%0d_data", i), ev_data, tbl[i].data);
         chk($sformatf("tbl%0d_mt", i), 32'(match_total), tbl[i].mt);
      end

      // Match gating: match without valid, then valid without match
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 0);
      chk("gate_empty", 32'(ev_empty), 32'd1);
      chk("gate_mt", 32'(match_total), 32'd0);

      // Overflow, lost flag and simultaneous read/write at full
      step(1, 0, 0, 0, 0);
      holdoff = 16'd0;
      for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0);
      chk("ovf_count", 32'(ev_count), 32'd8);
      chk("ovf_dt", 32'(drop_total), 32'd2);
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 1, 0);
      chk("full_count", 32'(ev_count), 32'd8);
      step(0, 1, 1, 1, 1);
      chk("rw_full_count", 32'(ev_count), 32'd8);
      chk("rw_full_dt", 32'(drop_total), 32'd2);
      lost_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (ev_data[31]) lost_seen++;
         step(0, 0, 0, 0, 1);
      end
      chk("lost_flag_count", 32'(lost_seen), 32'd1);
      chk("drained_empty", 32'(ev_empty), 32'd1);

      // Sample index wrap, preloaded near the top of the range
      step(1, 0, 0, 0, 0);
      force dut.sample_idx_q = 31'h7FFF_FFFE;
      m_idx = 32'h7FFF_FFFE;
      step(0, 0, 0, 0, 0);
      release dut.sample_idx_q;
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
      wrap_exp[0] = 32'h7FFF_FFFE; wrap_exp[1] = 32'h7FFF_FFFF; wrap_exp[2] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("wrap%0d", i), ev_data, wrap_exp[i]);
         step(0, 0, 0, 0, 1);
      end

      // Reset mid-holdoff with three entries queued; the match during reset is discarded
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      holdoff = 16'd100;
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      chk("pre_rst_count", 32'(ev_count), 32'd3);
      step(1, 1, 1, 1, 0);
      chk("midrst_empty", 32'(ev_empty), 32'd1);
      chk("midrst_mt", 32'(match_total), 32'd0);
      chk("midrst_dt", 32'(drop_total), 32'd0);
      step(0, 0, 1, 1, 0);
      chk("post_rst_count", 32'(ev_count), 32'd1);
      chk("post_rst_data", ev_data, 32'd0);

      // Randomized traffic against the reference model
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) holdoff = 16'($urandom_range(0, 6));
         step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/match_event_reporter.md
# match_event_reporter

Downstream consumer of the receive-path matched filter. Takes the filter's per-correlation `valid`/`match` result pulses and the receive sample strobe, and applies a programmable holdoff so one preamble yields one event. Each accepted event is timestamped with a free-running sample index and queued in a small show-ahead FIFO. The inband packet builder drains that FIFO with a read handshake.

## Interface

Parameters:
- `FIFO_AW`, default 3: log2 of event FIFO depth; default gives 8 entries.
- `IRQ_LEVEL`, default 1: FIFO occupancy at which `irq` asserts. Only used when `MATCH_REPORTER_IRQ_EN` is defined.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `rxstrobe`  in  1: one pulse per received complex sample; advances the sample index.
- `valid`  in  1: single-cycle pulse from the matched filter; a correlation result is present.
- `match`  in  1: correlation exceeded threshold; sampled only when `valid` is high.
- `holdoff`  in  16: number of samples during which further matches are suppressed after an accepted one; 0 disables holdoff.
- `ev_rd`  in  1: pop the FIFO head.
- `ev_data`  out  32: FIFO head as `{lost, sample_index[30:0]}`.
- `ev_empty`  out  1: FIFO holds no events.
- `ev_count`  out  FIFO_AW+1: current occupancy.
- `match_total`  out  16: saturating count of qualified matches, including suppressed ones.
- `drop_total`  out  16: saturating count of events dropped because the FIFO was full.
- `irq`  out  1: present only with `MATCH_REPORTER_IRQ_EN`.

## Operation

- A qualified match is `valid & match` in a given cycle. `match` is ignored when `valid` is low.
- `sample_index` is a 31-bit counter.
  - Increments on each `rxstrobe`.
  - Wraps from 0x7FFF_FFFF to 0.
  - The value recorded for an event is the registered counter value in the cycle the qualified match occurs, before that cycle's increment.
- Holdoff counter `ho_cnt` (16 bit):
  - A qualified match is accepted only if `ho_cnt == 0`, using the registered value.
  - On acceptance, `ho_cnt` loads `holdoff`.
  - Otherwise `ho_cnt` decrements on each `rxstrobe` while nonzero.
  - A match arriving in the same cycle that `ho_cnt` steps from 1 to 0 is suppressed.
  - A change to `holdoff` takes effect at the next acceptance.
- FIFO write: an accepted match writes `{lost, sample_index}`.
  - If the FIFO is full and no `ev_rd` occurs that cycle, the event is dropped, `drop_total` increments, and the sticky `lost` flag sets.
  - `lost` is carried in bit 31 of the next written event, then clears.
  - An accepted-but-dropped match still loads `ho_cnt`.
- FIFO read:
  - `ev_data` is show-ahead, valid whenever `ev_empty` is low.
  - `ev_rd` while empty is ignored and does not change state.
  - Write and read in the same cycle leave `ev_count` unchanged. This also holds at full: the write succeeds and nothing is dropped.
- Counters: `match_total` increments on every qualified match. Both counters saturate at 0xFFFF.
- Reset mid-operation clears the FIFO, counters, `ho_cnt`, `sample_index` and `lost` in the same cycle. Any match in that cycle is discarded.
- Reset values: `ev_empty`=1, `ev_count`=0, `ev_data`=0, `match_total`=0, `drop_total`=0, `irq`=0.

## Timing

- If a qualified match is accepted in cycle N, the entry is visible in cycle N+1: `ev_empty`=0, `ev_data` valid, `ev_count` incremented.
- `ev_rd` in cycle M: the next head (or `ev_empty`=1) appears in cycle M+1.
- `match_total` and `drop_total` update in cycle N+1.
- One event per cycle maximum. Back-to-back `valid` pulses are each evaluated.

## Configuration

- Macro `MATCH_REPORTER_IRQ_EN`.
- Defined: port `irq` exists. It is registered high from the cycle after `ev_count` reaches `IRQ_LEVEL` or more, and low the cycle after it falls below.
- Undefined: port `irq` and its logic are absent. All other behaviour is identical.

## Test plan

- Holdoff: `holdoff`=4, qualified matches at sample indices 10, 12, 14, 15.
  - Required: events for 10 and 15 only; `match_total`=4.
- Match gating: `valid`=0 with `match`=1 for 20 cycles, then `valid`=1 with `match`=0.
  - Required: no events; `match_total`=0.
- Overflow: `holdoff`=0, 10 matches with no reads, depth 8.
  - Required: `ev_count`=8 and `drop_total`=2.
  - Then one read plus one new match: that new event's bit 31 = 1.
  - A further match after another read: its bit 31 = 0.
- Simultaneous read and write at full.
  - Required: `ev_count` stays 8, `drop_total` unchanged, FIFO order preserved.
- Wrap: preload 0x7FFF_FFFE strobes, match on each of the next 3 samples.
  - Required: indices 0x7FFF_FFFE, 0x7FFF_FFFF, 0x0000_0000.
- Reset mid-holdoff with 3 entries queued.
  - Required: next cycle `ev_empty`=1, counters 0, and an immediate match is accepted at index 0.
  - With `MATCH_REPORTER_IRQ_EN` defined and `IRQ_LEVEL`=2: `irq` follows occupancy crossing 2 with one cycle of lag.
